bus_cs_ctrl: RTL and testbench

Parametrised bus-cycle controller for the 8088 minimum-mode system: latches the multiplexed address on ALE and decodes it against NUM_CS programmable memory/IO regions into a registered one-hot chip-select vector. It sequences the slave strobes (Load, OE, Wrenb) through an explicit state machine, with optional wait-state insertion on READY. It sits between the processor bus and the GenericIOM-class memory/IO devices, replacing separate latch, decoder and strobe FSM logic.

---
 rtl/bus_cs_ctrl_if.sv | 31 +++
 rtl/bus_cs_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bus_cs_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_cs_ctrl_if.sv
// Processor-side bus bundle for bus_cs_ctrl: the 8088 minimum-mode strobes in, and the decoded
// chip selects and slave strobes out. The controller connects through the slave modport.
interface bus_cs_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int NUM_CS = 4
);
  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] ABUS;
  logic [ADDR_W-1:0] Address;
  logic [NUM_CS-1:0] CS;
  logic              Load;
  logic              OE;
  logic              Wrenb;
  logic              READY;
  logic              Busy;
  logic              Miss;
  logic              Err;

  modport master (
    output ALE, IOM, RD, WR, ABUS,
    input  Address, CS, Load, OE, Wrenb, READY, Busy, Miss, Err
  );

  modport slave (
    input  ALE, IOM, RD, WR, ABUS,
    output Address, CS, Load, OE, Wrenb, READY, Busy, Miss, Err
  );
endinterface

// File: rtl/bus_cs_ctrl.sv
// 8088 bus-cycle controller: address latch, region decode to one-hot CS, and the strobe FSM.
// Optional wait-state insertion on READY is built only when BUS_WAIT_EN is defined.
module bus_cs_ctrl #(
  parameter int                       ADDR_W      = 20,
  parameter int                       NUM_CS      = 4,
  parameter logic [NUM_CS*ADDR_W-1:0] MAP_BASE    = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NUM_CS*ADDR_W-1:0] MAP_MASK    = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_CS-1:0]        MAP_IOM     = 4'b1100,
  parameter int                       WAIT_CYCLES = 2
) (
  input logic           CLK,
  input logic           RESET,
  bus_cs_ctrl_if.slave  bus
);

  if (NUM_CS < 1 || NUM_CS > 8 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_param_check
    $error("bus_cs_ctrl: NUM_CS or WAIT_CYCLES out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_XFER} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              miss_q, miss_d;
  logic              err_q, err_d;
  logic              seen_q, seen_d;
  logic [NUM_CS-1:0] hit_vec;
  logic              both_low;
  logic              oe, wrenb;
`ifdef BUS_WAIT_EN
  logic              ready_q, ready_d;
  logic [3:0]        cnt_q, cnt_d;
`endif

  // Walking from the top index down lets the lowest matching region overwrite any higher one.
  always_comb begin
    hit_vec = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (((bus.ABUS & MAP_MASK[i*ADDR_W +: ADDR_W]) == MAP_BASE[i*ADDR_W +: ADDR_W]) &&
          (bus.IOM == MAP_IOM[i])) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
    end
  end

  assign both_low = !bus.RD && !bus.WR;

  always_comb begin
    oe    = 1'b0;
    wrenb = 1'b0;
    if (state_q == S_XFER && !both_low) begin
      oe    = !bus.RD;
      wrenb = !bus.WR;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    address_d = address_q;
    cs_d      = cs_q;
    seen_d    = seen_q;
    miss_d    = 1'b0;
    err_d     = 1'b0;
`ifdef BUS_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.ALE) begin
          address_d = bus.ABUS;
          if (|hit_vec) begin
            cs_d    = hit_vec;
            state_d = S_ADDR;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        seen_d  = 1'b0;
        state_d = S_XFER;
`ifdef BUS_WAIT_EN
        if (WAIT_CYCLES > 0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
`endif
      end
`ifdef BUS_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_XFER;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      S_XFER: begin
        if (both_low) begin
          err_d   = 1'b1;
          cs_d    = '0;
          state_d = S_IDLE;
        end else if (bus.RD && bus.WR) begin
          // Idle strobes only end the cycle once a strobe has actually been seen.
          if (seen_q) begin
            cs_d    = '0;
            state_d = S_IDLE;
          end
        end else begin
          seen_d = 1'b1;
        end
      end
      default: begin
        cs_d    = '0;
        state_d = S_IDLE;
      end
    endcase
    load_d = (state_d == S_ADDR);
    busy_d = (state_d != S_IDLE);
`ifdef BUS_WAIT_EN
    ready_d = (state_d != S_WAIT);
`endif
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state_q   <= S_IDLE;
      address_q <= '0;
      cs_q      <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      miss_q    <= 1'b0;
      err_q     <= 1'b0;
      seen_q    <= 1'b0;
`ifdef BUS_WAIT_EN
      ready_q   <= 1'b1;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
`ifdef BUS_WAIT_EN
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.Address = address_q;
  assign bus.CS      = cs_q;
  assign bus.Load    = load_q;
  assign bus.OE      = oe;
  assign bus.Wrenb   = wrenb;
  assign bus.Busy    = busy_q;
  assign bus.Miss    = miss_q;
  assign bus.Err     = err_q;
`ifdef BUS_WAIT_EN
  assign bus.READY   = ready_q;
`else
  assign bus.READY   = 1'b1;
`endif

endmodule

// File: tb/tb_bus_cs_ctrl.sv
// Directed bench for bus_cs_ctrl: decode, strobe sequencing, wait states, miss/error pulses, reset.
module tb_bus_cs_ctrl;

`ifdef BUS_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  typedef struct {
    logic [19:0] addr;
    logic [3:0]  cs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  bus_cs_ctrl_if #(.ADDR_W(20), .NUM_CS(4)) bus ();

  bus_cs_ctrl dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},  32'(bus.Address), 32'h0);
    chk({tag, "_cs"},    32'(bus.CS),      32'h0);
    chk({tag, "_load"},  32'(bus.Load),    32'h0);
    chk({tag, "_oe"},    32'(bus.OE),      32'h0);
    chk({tag, "_wrenb"}, 32'(bus.Wrenb),   32'h0);
    chk({tag, "_ready"}, 32'(bus.READY),   32'h1);
    chk({tag, "_busy"},  32'(bus.Busy),    32'h0);
    chk({tag, "_miss"},  32'(bus.Miss),    32'h0);
    chk({tag, "_err"},   32'(bus.Err),     32'h0);
  endtask

  // Pulse ALE for one edge; expectation pushed at drive time, popped once the DUT has reacted.
  task automatic start_cycle(input logic [19:0] a, input logic iom, input logic [3:0] exp_cs);
    exp_t e;
    bus.ALE  = 1'b1;
    bus.ABUS = a;
    bus.IOM  = iom;
    e.addr   = a;
    e.cs     = exp_cs;
    sb.push_back(e);
    step();
    bus.ALE = 1'b0;
    e = sb.pop_front();
    chk("addr_latch", 32'(bus.Address), 32'(e.addr));
    chk("cs_decode",  32'(bus.CS),      32'(e.cs));
    if (e.cs != 4'b0000) begin
      chk("load_high", 32'(bus.Load), 32'h1);
      chk("busy_high", 32'(bus.Busy), 32'h1);
      chk("no_miss",   32'(bus.Miss), 32'h0);
    end else begin
      chk("miss_pulse", 32'(bus.Miss), 32'h1);
      chk("miss_busy",  32'(bus.Busy), 32'h0);
      chk("miss_load",  32'(bus.Load), 32'h0);
    end
  endtask

  // Called in ADDR with the strobe already driven; returns once XFER has been entered.
  task automatic to_xfer();
    int waits = 0;
    #1;
    chk("oe_in_addr",    32'(bus.OE),    32'h0);
    chk("wrenb_in_addr", 32'(bus.Wrenb), 32'h0);
    chk("ready_in_addr", 32'(bus.READY), 32'h1);
    step();
    chk("load_drop", 32'(bus.Load), 32'h0);
    while (bus.READY === 1'b0 && waits < 20) begin
      chk("oe_in_wait", 32'(bus.OE), 32'h0);
      waits++;
      step();
    end
    chk("wait_count", 32'(waits), 32'(W));
  endtask

  task automatic finish_cycle();
    step();
    chk("busy_hold", 32'(bus.Busy), 32'h1);
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    step();
    chk("cs_release",    32'(bus.CS),    32'h0);
    chk("busy_release",  32'(bus.Busy),  32'h0);
    chk("oe_release",    32'(bus.OE),    32'h0);
    chk("wrenb_release", 32'(bus.Wrenb), 32'h0);
  endtask

  initial begin
    bus.ALE  = 1'b0;
    bus.IOM  = 1'b0;
    bus.RD   = 1'b1;
    bus.WR   = 1'b1;
    bus.ABUS = '0;
    rst      = 1'b1;
    step();
    step();
    check_reset_values("por");
    rst = 1'b0;
    step();

    // Memory read to region 0
    start_cycle(20'h00123, 1'b0, 4'b0001);
    bus.RD = 1'b0;
    to_xfer();
    chk("rd_oe",    32'(bus.OE),    32'h1);
    chk("rd_wrenb", 32'(bus.Wrenb), 32'h0);
    chk("rd_cs",    32'(bus.CS),    32'h1);
    finish_cycle();

    // IO writes to regions 2 and 3, back to back
    start_cycle(20'h0FF05, 1'b1, 4'b0100);
    bus.WR = 1'b0;
    to_xfer();
    chk("wr_wrenb", 32'(bus.Wrenb), 32'h1);
    chk("wr_oe",    32'(bus.OE),    32'h0);
    finish_cycle();
    start_cycle(20'h01C40, 1'b1, 4'b1000);
    bus.WR = 1'b0;
    to_xfer();
    chk("wr3_wrenb", 32'(bus.Wrenb), 32'h1);
    finish_cycle();

    // Same address in memory space falls into region 0; high half into region 1
    start_cycle(20'h0FF05, 1'b0, 4'b0001);
    bus.RD = 1'b0;
    to_xfer();
    finish_cycle();
    start_cycle(20'hABCDE, 1'b0, 4'b0010);
    bus.RD = 1'b0;
    to_xfer();
    finish_cycle();

    // Miss
    start_cycle(20'h00100, 1'b1, 4'b0000);
    step();
    chk("miss_clear", 32'(bus.Miss),    32'h0);
    chk("miss_addr",  32'(bus.Address), 32'h00100);

    // Protocol error
    start_cycle(20'h00123, 1'b0, 4'b0001);
    to_xfer();
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    #1;
    chk("err_oe",    32'(bus.OE),    32'h0);
    chk("err_wrenb", 32'(bus.Wrenb), 32'h0);
    step();
    chk("err_pulse", 32'(bus.Err),  32'h1);
    chk("err_busy",  32'(bus.Busy), 32'h0);
    chk("err_cs",    32'(bus.CS),   32'h0);
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    step();
    chk("err_clear", 32'(bus.Err), 32'h0);

    // ALE during XFER is ignored
    start_cycle(20'h0FF05, 1'b1, 4'b0100);
    bus.WR = 1'b0;
    to_xfer();
    bus.ALE  = 1'b1;
    bus.ABUS = 20'h00123;
    bus.IOM  = 1'b0;
    step();
    bus.ALE = 1'b0;
    chk("xfer_ale_addr", 32'(bus.Address), 32'h0FF05);
    chk("xfer_ale_cs",   32'(bus.CS),      32'h4);
    chk("xfer_ale_load", 32'(bus.Load),    32'h0);
    finish_cycle();

    // Reset mid-cycle (WAIT when waits are built) with a simultaneous ALE
    start_cycle(20'h00123, 1'b0, 4'b0001);
    bus.RD = 1'b0;
    step();
    chk("pre_reset_ready", 32'(bus.READY), (W > 0) ? 32'h0 : 32'h1);
    rst      = 1'b1;
    bus.ALE  = 1'b1;
    bus.ABUS = 20'h80000;
    step();
    check_reset_values("mid_reset");
    rst     = 1'b0;
    bus.ALE = 1'b0;
    bus.RD  = 1'b1;
    step();
    check_reset_values("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
